display_scheduler: RTL



---
 rtl/display_pkg.sv | 39 +++
 rtl/disp_blink_gen.sv | 54 +++++
 rtl/display_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and timing helpers for the display scheduler and its blink
// generator.
package display_pkg;

  // Scheduler states. The encoding carries no meaning beyond being distinct.
  typedef enum logic [2:0] {
    ST_OFF,
    ST_TIME,
    ST_SET_TIME,
    ST_SET_ALARM,
    ST_PREVIEW,
    ST_RING
  } state_e;

  // Encodings driven on src; 2'b11 is reserved and never produced.
  localparam logic [1:0] SRC_TIME  = 2'b00;
  localparam logic [1:0] SRC_ALARM = 2'b01;
  localparam logic [1:0] SRC_BLANK = 2'b10;

  // Longest preview the counter must be able to hold, in seconds.
  localparam int unsigned PREVIEW_S_MAX = 15;

  // Cycles per blink half-period; clamped to 1 so the generator always
  // toggles even when the clock is slower than twice the blink rate.
  function automatic int unsigned half_period_cycles(input int unsigned clk_hz,
                                                     input int unsigned blink_hz);
    int unsigned h;
    h = clk_hz / (2 * blink_hz);
    return (h == 0) ? 1 : h;
  endfunction

  // Cycles in a preview of the given length. 64-bit so 15 s at a fast
  // clock cannot overflow during elaboration.
  function automatic longint unsigned preview_cycles(input int unsigned clk_hz,
                                                     input int unsigned secs);
    return longint'(clk_hz) * longint'(secs);
  endfunction

endpackage

// File: rtl/disp_blink_gen.sv
// Prescaled phase toggler for digit blinking and alarm flashing.
// phase = 1 means lit. restart forces the phase lit and clears the prescaler,
// so the first dark interval starts exactly one half-period later.
// phase reports the value the phase register takes at the coming edge, which
// lets a downstream output register show a restart on the very next cycle.
module disp_blink_gen
  import display_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned BLINK_HZ = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase
);

  localparam int unsigned HALF = half_period_cycles(CLK_HZ, BLINK_HZ);
  localparam int          CW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Prescaler advance and phase toggle at the end of each half-period.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CW'(HALF - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  // Prescaler and phase registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_d;

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates the shared 4-digit display between current time, alarm time and
// blank. Sequences the post-arm alarm preview, flashes while ringing and
// blinks digits in the set modes.
// Optional feature: define DISPLAY_SET_BLINK_EN to blink all four digits in
// SET_TIME/SET_ALARM; otherwise they stay steadily lit (RING always flashes).
module display_scheduler
  import display_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BLINK_HZ  = 2,
  parameter int unsigned PREVIEW_S = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] time_bcd_min,
  input  logic [7:0] time_bcd_hr,
  input  logic [7:0] alarm_bcd_min,
  input  logic [7:0] alarm_bcd_hr,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       alarm_arm,
  input  logic       ringing,
  input  logic       power_on,
  output logic [7:0] disp_min,
  output logic [7:0] disp_hr,
  output logic [3:0] digit_en,
  output logic [1:0] src
);

  localparam longint unsigned PV_MAX = preview_cycles(CLK_HZ, PREVIEW_S_MAX);
  localparam longint unsigned PV_CYC = preview_cycles(CLK_HZ, PREVIEW_S);
  localparam int              PW     = $clog2(PV_MAX + 1);

  state_e        state_q, state_d;
  logic          arm_q;
  logic [PW-1:0] pv_cnt_q, pv_cnt_d;
  logic          arm_edge, pv_load, pv_active;
  logic          blink_restart, blink_phase;
  logic [7:0]    min_q, min_d, hr_q, hr_d;
  logic [3:0]    en_q, en_d;
  logic [1:0]    src_q, src_d;

  // A rising arm edge only starts (or restarts) a preview while the plain
  // time view or a preview is on screen. pv_cnt_q holds the preview cycles
  // still to run after the current one, so zero means disarmed.
  assign arm_edge  = alarm_arm & ~arm_q;
  assign pv_load   = arm_edge && (state_q == ST_TIME || state_q == ST_PREVIEW);
  assign pv_active = pv_load || (pv_cnt_q != '0);

  // Next-state priority: power, ringing, set alarm, set time, preview, time.
  always_comb begin
    state_d = ST_TIME;
    if (!power_on)      state_d = ST_OFF;
    else if (ringing)   state_d = ST_RING;
    else if (set_alarm) state_d = ST_SET_ALARM;
    else if (set_time)  state_d = ST_SET_TIME;
    else if (pv_active) state_d = ST_PREVIEW;
  end

  // Preview countdown; any state other than PREVIEW cancels it for good.
  always_comb begin
    pv_cnt_d = '0;
    if (state_d == ST_PREVIEW) begin
      if (pv_load) pv_cnt_d = PW'(PV_CYC - 1);
      else         pv_cnt_d = pv_cnt_q - 1'b1;
    end
  end

  // Every entry into a blinking state starts the phase lit.
  assign blink_restart = (state_d != state_q) &&
                         (state_d == ST_SET_TIME || state_d == ST_SET_ALARM ||
                          state_d == ST_RING);

  disp_blink_gen #(
    .CLK_HZ  (CLK_HZ),
    .BLINK_HZ(BLINK_HZ)
  ) u_blink (
    .clk    (clk),
    .rst    (rst),
    .restart(blink_restart),
    .phase  (blink_phase)
  );

  // Output selection for the state being entered, registered below.
  always_comb begin
    src_d = SRC_TIME;
    en_d  = 4'b1111;
    min_d = time_bcd_min;
    hr_d  = time_bcd_hr;
    unique case (state_d)
      ST_OFF: begin
        src_d = SRC_BLANK;
        en_d  = 4'b0000;
        min_d = 8'h00;
        hr_d  = 8'h00;
      end
      ST_TIME: ;
      ST_PREVIEW: begin
        src_d = SRC_ALARM;
        min_d = alarm_bcd_min;
        hr_d  = alarm_bcd_hr;
      end
      ST_SET_TIME: begin
`ifdef DISPLAY_SET_BLINK_EN
        en_d = {4{blink_phase}};
`endif
      end
      ST_SET_ALARM: begin
        src_d = SRC_ALARM;
        min_d = alarm_bcd_min;
        hr_d  = alarm_bcd_hr;
`ifdef DISPLAY_SET_BLINK_EN
        en_d  = {4{blink_phase}};
`endif
      end
      ST_RING: en_d = {4{blink_phase}};
      default: begin
        src_d = SRC_BLANK;
        en_d  = 4'b0000;
        min_d = 8'h00;
        hr_d  = 8'h00;
      end
    endcase
  end

  // State, edge detector, preview counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_TIME;
      arm_q    <= 1'b0;
      pv_cnt_q <= '0;
      src_q    <= SRC_TIME;
      en_q     <= 4'b0000;
      min_q    <= 8'h00;
      hr_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      arm_q    <= alarm_arm;
      pv_cnt_q <= pv_cnt_d;
      src_q    <= src_d;
      en_q     <= en_d;
      min_q    <= min_d;
      hr_q     <= hr_d;
    end
  end

  assign disp_min = min_q;
  assign disp_hr  = hr_q;
  assign digit_en = en_q;
  assign src      = src_q;

endmodule
